remote_comm_e: RTL and testbench

//  Bench/host-side command link to the Knight robot. Takes a 16-bit command, sends it over an
//  8N1 UART as two bytes (high byte first), then receives the robot's 1-byte response.

---
 rtl/remote_comm_e.sv | 229 ++++++++++++++++++++++
 tb/tb_remote_comm_e.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm_e.sv
// Host-side command link: sends a 16-bit command as two 8N1 UART bytes, high byte first,
// and receives single-byte responses on an independent UART receiver.
module remote_comm_e #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [1:0] {CMD_IDLE, CMD_HIGH, CMD_LOW} cmd_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- command sequencer ----------------
  cmd_state_e cmd_state_q, cmd_state_d;
  logic [7:0] cmd_lo_q, cmd_lo_d;
  logic       cmd_sent_q, cmd_sent_d;
  logic       cmd_accept;
  logic       tx_start;
  logic [7:0] tx_start_byte;
  logic       tx_done;

  always_comb begin
    cmd_state_d   = cmd_state_q;
    cmd_lo_d      = cmd_lo_q;
    cmd_sent_d    = cmd_sent_q;
    cmd_accept    = 1'b0;
    tx_start      = 1'b0;
    tx_start_byte = cmd[15:8];
    case (cmd_state_q)
      CMD_IDLE: begin
        if (send_cmd) begin
          cmd_accept    = 1'b1;
          cmd_lo_d      = cmd[7:0];
          cmd_sent_d    = 1'b0;
          tx_start      = 1'b1;
          tx_start_byte = cmd[15:8];
          cmd_state_d   = CMD_HIGH;
        end
      end
      CMD_HIGH: begin
        // Low byte is reloaded on the stop-bit's final clock, so the two frames abut.
        if (tx_done) begin
          tx_start      = 1'b1;
          tx_start_byte = cmd_lo_q;
          cmd_state_d   = CMD_LOW;
        end
      end
      CMD_LOW: begin
        if (tx_done) begin
          cmd_sent_d  = 1'b1;
          cmd_state_d = CMD_IDLE;
        end
      end
      default: cmd_state_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_state_q <= CMD_IDLE;
      cmd_lo_q    <= '0;
      cmd_sent_q  <= 1'b0;
    end else begin
      cmd_state_q <= cmd_state_d;
      cmd_lo_q    <= cmd_lo_d;
      cmd_sent_q  <= cmd_sent_d;
    end
  end

  // ---------------- UART transmitter ----------------
  logic          tx_busy_q, tx_busy_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;

  assign tx_done = tx_busy_q && (tx_baud_q == BAUD_LAST) && (tx_bit_q == 4'd9);

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    if (tx_busy_q) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          // Shift register carries data then the stop '1' filled in from the top.
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_d = tx_baud_q + 1'b1;
      end
    end
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, tx_start_byte};
      tx_baud_d  = '0;
      tx_bit_d   = 4'd0;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- UART receiver ----------------
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    if (cmd_accept) resp_rdy_d = 1'b0;
    // Frame completion is evaluated after the clear so a coincident set wins.
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
            resp_rdy_d = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          resp_d     = rx_shift_q;
          resp_rdy_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign TX       = tx_q;
  assign cmd_sent = cmd_sent_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;

endmodule

// File: tb/tb_remote_comm_e.sv
// Testbench for remote_comm_e: TX frames decoded by a monitor into a queue, RX responses
// checked against an expected-byte queue filled as stimulus is driven.
module tb_remote_comm_e;

  localparam int BAUD = 434;
  localparam int HALF = BAUD / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        mon_en = 1'b1;
  logic        send_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        rx_line;
  logic        tx_w;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] tx_got[$];
  bit         tx_ok[$];
  logic [7:0] rx_exp[$];

  assign rx_line = loopback ? tx_w : rx_drv;

  always #5 clk = ~clk;

  remote_comm_e #(.BAUD_DIV(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (rx_line),
    .TX       (tx_w),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  // Decodes every TX frame at bit centres.
  initial begin : tx_monitor
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge tx_w);
      if (mon_en) begin
        repeat (HALF) @(posedge clk);
        #1;
        ok = (tx_w === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(posedge clk);
          #1;
          b[i] = tx_w;
        end
        repeat (BAUD) @(posedge clk);
        #1;
        ok = ok && (tx_w === 1'b1);
        tx_got.push_back(b);
        tx_ok.push_back(ok);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_send(input logic [15:0] c);
    cmd      = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    step(1);
    checks++; if (tx_w !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_w); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent got %b exp 0", cmd_sent); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h exp 00", resp); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step(1);
      if (resp_rdy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL idle_rx_no_frame got resp_rdy=1 exp 0"); end
    $display("test_reset done");
  endtask

  task automatic test_cmd_2000();
    int n;
    logic [7:0] e, g;
    bit ok;
    tx_exp.push_back(8'h20);
    tx_exp.push_back(8'h00);
    do_send(16'h2000);
    n = 0;
    while (cmd_sent !== 1'b1 && n < 12000) begin step(1); n++; end
    checks++;
    if (cmd_sent !== 1'b1 || n < 20 * BAUD || n > 20 * BAUD + 3)
      begin errors++; $display("FAIL cmd2000_latency got %0d cycles sent=%b exp %0d..%0d", n, cmd_sent, 20 * BAUD, 20 * BAUD + 3); end
    step(5);
    checks++; if (tx_got.size() != tx_exp.size()) begin errors++; $display("FAIL cmd2000_frames got %0d exp %0d", tx_got.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_got.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_got.pop_front(); ok = tx_ok.pop_front();
      checks++; if (g !== e || !ok) begin errors++; $display("FAIL cmd2000_byte got %h framing_ok=%0d exp %h", g, ok, e); end
      $display("tx byte %h (exp %h)", g, e);
    end
    tx_exp.delete(); tx_got.delete(); tx_ok.delete();
  endtask

  task automatic test_loopback();
    int n;
    logic [7:0] e, g;
    bit ok;
    loopback = 1'b1;
    rx_exp.push_back(8'h4B); rx_exp.push_back(8'hF1);
    tx_exp.push_back(8'h4B); tx_exp.push_back(8'hF1);
    do_send(16'h4BF1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (resp_rdy !== 1'b1 && n < 6000) begin step(1); n++; end
      e = rx_exp.pop_front();
      checks++; if (resp_rdy !== 1'b1 || resp !== e) begin errors++; $display("FAIL loop_resp%0d got rdy=%b resp=%h exp rdy=1 resp=%h", k, resp_rdy, resp, e); end
      $display("rx byte %h (exp %h)", resp, e);
      if (k == 0) begin
        n = 0;
        while (resp_rdy !== 1'b0 && n < 2000) begin step(1); n++; end
        checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL loop_rdy_clear got %b exp 0", resp_rdy); end
      end
    end
    n = 0;
    while (cmd_sent !== 1'b1 && n < 2000) begin step(1); n++; end
    checks++; if (cmd_sent !== 1'b1) begin errors++; $display("FAIL loop_cmd_sent got %b exp 1", cmd_sent); end
    step(5);
    loopback = 1'b0;
    checks++; if (tx_got.size() != tx_exp.size()) begin errors++; $display("FAIL loop_frames got %0d exp %0d", tx_got.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_got.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_got.pop_front(); ok = tx_ok.pop_front();
      checks++; if (g !== e || !ok) begin errors++; $display("FAIL loop_tx_byte got %h framing_ok=%0d exp %h", g, ok, e); end
    end
    tx_exp.delete(); tx_got.delete(); tx_ok.delete(); rx_exp.delete();
  endtask

  task automatic test_rx_a5();
    int n;
    logic [7:0] frame_byte, e, g;
    bit ok;
    frame_byte = 8'hA5;
    rx_exp.push_back(frame_byte);
    rx_drv = 1'b0;
    step(BAUD);
    for (int i = 0; i < 8; i++) begin rx_drv = frame_byte[i]; step(BAUD); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL a5_rdy_cleared_by_start got %b exp 0", resp_rdy); end
    rx_drv = 1'b1;
    n = 0;
    while (resp_rdy !== 1'b1 && n < BAUD) begin step(1); n++; end
    checks++;
    if (resp_rdy !== 1'b1 || n < HALF - 4 || n > HALF + 8)
      begin errors++; $display("FAIL a5_stop_centre got rdy=%b at %0d exp 1 at %0d..%0d", resp_rdy, n, HALF - 4, HALF + 8); end
    e = rx_exp.pop_front();
    checks++; if (resp !== e) begin errors++; $display("FAIL a5_resp got %h exp %h", resp, e); end
    $display("rx byte %h (exp %h)", resp, e);
    tx_exp.push_back(8'h0F); tx_exp.push_back(8'h0E);
    do_send(16'h0F0E);
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL a5_rdy_clear_on_send got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL a5_resp_hold got %h exp a5", resp); end
    n = 0;
    while (cmd_sent !== 1'b1 && n < 12000) begin step(1); n++; end
    step(5);
    checks++; if (tx_got.size() != tx_exp.size()) begin errors++; $display("FAIL a5_frames got %0d exp %0d", tx_got.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_got.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_got.pop_front(); ok = tx_ok.pop_front();
      checks++; if (g !== e || !ok) begin errors++; $display("FAIL a5_tx_byte got %h framing_ok=%0d exp %h", g, ok, e); end
    end
    tx_exp.delete(); tx_got.delete(); tx_ok.delete();
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [7:0] e, g;
    bit ok;
    tx_exp.push_back(8'h12); tx_exp.push_back(8'h34);
    do_send(16'h1234);
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL busy_sent_cleared got %b exp 0", cmd_sent); end
    step(100);
    do_send(16'hFFFF);
    n = 0;
    while (cmd_sent !== 1'b1 && n < 12000) begin step(1); n++; end
    checks++; if (cmd_sent !== 1'b1) begin errors++; $display("FAIL busy_cmd_sent got %b exp 1", cmd_sent); end
    step(BAUD);
    checks++; if (tx_w !== 1'b1 || cmd_sent !== 1'b1) begin errors++; $display("FAIL busy_idle_after got tx=%b sent=%b exp 1 1", tx_w, cmd_sent); end
    checks++; if (tx_got.size() != tx_exp.size()) begin errors++; $display("FAIL busy_frames got %0d exp %0d", tx_got.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_got.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_got.pop_front(); ok = tx_ok.pop_front();
      checks++; if (g !== e || !ok) begin errors++; $display("FAIL busy_tx_byte got %h framing_ok=%0d exp %h", g, ok, e); end
      $display("tx byte %h (exp %h)", g, e);
    end
    tx_exp.delete(); tx_got.delete(); tx_ok.delete();
  endtask

  task automatic test_rx_glitch();
    rx_drv = 1'b0;
    step(100);
    rx_drv = 1'b1;
    step(12 * BAUD);
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL glitch_resp got %h exp a5", resp); end
    $display("test_rx_glitch done");
  endtask

  task automatic test_midframe_reset();
    int n;
    logic [7:0] e, g;
    bit ok;
    mon_en = 1'b0;
    do_send(16'hABCD);
    step(3 * BAUD + 200);
    checks++; if (tx_w !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx got %b exp 0", tx_w); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_w !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", tx_w); end
    checks++; if (resp !== 8'h00 || resp_rdy !== 1'b0 || cmd_sent !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got resp=%h rdy=%b sent=%b exp 00 0 0", resp, resp_rdy, cmd_sent); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(5);
    checks++; if (tx_w !== 1'b1) begin errors++; $display("FAIL midrst_after_tx got %b exp 1", tx_w); end
    tx_got.delete(); tx_ok.delete();
    mon_en = 1'b1;
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'hC3);
    do_send(16'h5AC3);
    n = 0;
    while (cmd_sent !== 1'b1 && n < 12000) begin step(1); n++; end
    checks++; if (cmd_sent !== 1'b1) begin errors++; $display("FAIL midrst_cmd_sent got %b exp 1", cmd_sent); end
    step(5);
    checks++; if (tx_got.size() != tx_exp.size()) begin errors++; $display("FAIL midrst_frames got %0d exp %0d", tx_got.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_got.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_got.pop_front(); ok = tx_ok.pop_front();
      checks++; if (g !== e || !ok) begin errors++; $display("FAIL midrst_tx_byte got %h framing_ok=%0d exp %h", g, ok, e); end
      $display("tx byte %h (exp %h)", g, e);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_2000();
    test_loopback();
    test_rx_a5();
    test_busy_ignore();
    test_rx_glitch();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
